// File: rtl/math_pkg.sv
// Shared constants for the 42x35 multiplier datapath and its round/saturate post-processor.
package math_pkg;

  localparam int MATH_MULT_35_LAT         = 6;
  localparam int MATH_MULT_35_PROD_W      = 70;
  localparam int MATH_MULT_35_ROUND_SUM_W = 71;

  // Half-LSB of the shifted result: 2^(shift-1), or zero when no shift is applied.
  function automatic logic [MATH_MULT_35_ROUND_SUM_W-1:0] round_half(input logic [5:0] shift);
    round_half = '0;
    if (shift != 6'd0) begin
      round_half[shift - 6'd1] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/math_fifo_sync.sv
// Generic single-clock FIFO: registered storage, head visible one cycle after the write, no fall-through.
module math_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/math_mult_35_round.sv
// Post-processor for math_mult_35: credit-based operand admission, tag line tracking the
// multiply pipeline, round-half-up shift with saturation, and a result FIFO.
module math_mult_35_round
  import math_pkg::*;
#(
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int MULT_LAT   = MATH_MULT_35_LAT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [MATH_MULT_35_PROD_W-1:0] prod,
  input  logic [5:0]                     cfg_shift,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [OUT_W-1:0]               m_data,
  output logic                           m_sat,
  input  logic                           sat_clr,
  output logic [15:0]                    sat_count,
  output logic                           idle
);

  localparam int SW = MATH_MULT_35_ROUND_SUM_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic                accept, pop;
  logic [MULT_LAT-1:0] tag_q, tag_d;
  logic                tag_end;

  logic [SW-1:0]       sum, shifted;
  logic [OUT_W-1:0]    rnd_data_d, rnd_data_q;
  logic                rnd_sat_d, rnd_sat_q;
  logic                rnd_vld_q;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         sat_cnt_q, sat_cnt_d;

  logic [OUT_W:0]      fifo_head;
  logic                fifo_full, fifo_empty;

  assign accept = s_valid && s_ready;
  assign pop    = m_valid && m_ready;

  // The tag line mirrors the multiplier pipeline; a set bit at the end means prod is ours.
  assign tag_d   = MULT_LAT'({tag_q, accept});
  assign tag_end = tag_q[MULT_LAT-1];

  always_comb begin
    sum        = SW'(prod) + round_half(cfg_shift);
    shifted    = sum >> cfg_shift;
    rnd_sat_d  = |(shifted >> OUT_W);
    rnd_data_d = rnd_sat_d ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      rnd_vld_q  <= 1'b0;
      rnd_data_q <= '0;
      rnd_sat_q  <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      rnd_vld_q <= tag_end;
      if (tag_end) begin
        rnd_data_q <= rnd_data_d;
        rnd_sat_q  <= rnd_sat_d;
      end
    end
  end

  // Credits cover both pipeline and FIFO, so every admitted pair has a slot waiting.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (rnd_vld_q && rnd_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      sat_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  math_fifo_sync #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (rnd_vld_q),
    .wr_data_i ({rnd_sat_q, rnd_data_q}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign m_valid          = !fifo_empty;
  assign {m_sat, m_data}  = m_valid ? fifo_head : '0;
  assign s_ready          = (cnt_q < CNT_MAX);
  assign idle             = (cnt_q == '0);
  assign sat_count        = sat_cnt_q;

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rnd_vld_q && fifo_full));

endmodule

// File: tb/tb_math_mult_35_round.sv
// Bench for math_mult_35_round: multiplier model, directed vector table, scoreboard with
// an arithmetic rounding reference, and multi-cycle corner-case sequences.
module tb_math_mult_35_round;

  localparam int OUT_W = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [69:0] prod;
  logic [5:0]  cfg_shift;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_sat;
  logic        sat_clr;
  logic [15:0] sat_count;
  logic        idle;

  logic [41:0] dina;
  logic [34:0] dinb;
  logic [69:0] mpipe [LAT];

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_out = 0;
  int cyc = 0;
  int first_out = -1;
  int last_out = -1;

  typedef struct {
    logic [31:0] d;
    logic        s;
  } exp_t;

  typedef struct {
    logic [41:0] a;
    logic [34:0] b;
    logic [5:0]  sh;
    logic [31:0] d;
    logic        s;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];

  math_mult_35_round #(
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (DEPTH),
    .MULT_LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .prod      (prod),
    .cfg_shift (cfg_shift),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sat     (m_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Free-running multiplier model, never stalls and is not reset.
  always @(posedge clk) begin
    mpipe[0] <= 70'(77'(dina) * 77'(dinb));
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign prod = mpipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // round(p / 2^sh) half-up == floor((2p + 2^sh) / 2^(sh+1)), then clamp to OUT_W bits.
  function automatic void ref_round(input logic [69:0] p, input logic [5:0] sh,
                                    output logic [31:0] d, output logic sat);
    logic [72:0] t;
    t = {3'b000, p} << 1;
    t = t + (73'(1) << sh);
    t = t >> (int'(sh) + 1);
    if (t > 73'h0_FFFF_FFFF) begin
      d   = 32'hFFFF_FFFF;
      sat = 1'b1;
    end else begin
      d   = t[31:0];
      sat = 1'b0;
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [69:0] p;
    cyc++;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (s_valid && s_ready) begin
        p = 70'(77'(dina) * 77'(dinb));
        ref_round(p, cfg_shift, e.d, e.s);
        sb.push_back(e);
        n_acc++;
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          fail_now("sb_unexpected_valid");
        end else begin
          chk("sb_data", 64'(m_data), 64'(sb[0].d));
          chk("sb_sat", 64'(m_sat), 64'(sb[0].s));
          if (m_ready) begin
            void'(sb.pop_front());
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    dina = {7'd0, 3'($urandom_range(7, 0)), 32'($urandom)};
    dinb = {3'($urandom_range(7, 0)), 32'($urandom)};
  endtask

  // Presents one pair and returns just after the accepting edge.
  task automatic issue(input logic [41:0] a, input logic [34:0] b);
    int g;
    g = 0;
    step();
    dina    = a;
    dinb    = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready) fail_now("issue_timeout");
    step();
    s_valid = 1'b0;
  endtask

  // Counts negedges from the accepting edge to the first m_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid && lat < 40);
    if (!m_valid) fail_now("result_timeout");
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!idle && g < 80);
    chk("wait_idle", 64'(idle), 64'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, bad, a0, b0, drops;
    logic [69:0] p;
    logic [31:0] ed;
    logic        es;

    vt[0]  = '{42'd3,            35'h8000,        6'd16, 32'd2,          1'b0};
    vt[1]  = '{42'd5,            35'd1,           6'd1,  32'd3,          1'b0};
    vt[2]  = '{42'd7,            35'd1,           6'd2,  32'd2,          1'b0};
    vt[3]  = '{42'd5,            35'd1,           6'd2,  32'd1,          1'b0};
    vt[4]  = '{42'h12345,        35'd1,           6'd0,  32'h12345,      1'b0};
    vt[5]  = '{42'hFFFF_FFFF,    35'd1,           6'd0,  32'hFFFF_FFFF,  1'b0};
    vt[6]  = '{42'h1_0000_0000,  35'd1,           6'd0,  32'hFFFF_FFFF,  1'b1};
    vt[7]  = '{42'h1_FFFF_FFFF,  35'd1,           6'd1,  32'hFFFF_FFFF,  1'b1};
    vt[8]  = '{42'h1_FFFF_FFFE,  35'd1,           6'd1,  32'hFFFF_FFFF,  1'b0};
    vt[9]  = '{42'h7_FFFF_FFFF,  35'h7_FFFF_FFFF, 6'd63, 32'h80,         1'b0};
    vt[10] = '{42'd0,            35'd12345,       6'd5,  32'd0,          1'b0};
    vt[11] = '{42'd11,           35'd1,           6'd2,  32'd3,          1'b0};

    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; sat_clr = 1'b0;
    cfg_shift = 6'd0; dina = '0; dinb = '0;

    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_sat", 64'(m_sat), 64'd0);
    step();
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(s_ready && !m_valid && idle && sat_count == 16'd0)) bad++;
    end
    chk("post_reset_hold", 64'(bad), 64'd0);

    // Directed vectors, one at a time, with latency checked on each.
    for (int i = 0; i < 12; i++) begin
      step();
      cfg_shift = vt[i].sh;
      issue(vt[i].a, vt[i].b);
      wait_result(lat);
      chk($sformatf("vec%0d_data", i), 64'(m_data), 64'(vt[i].d));
      chk($sformatf("vec%0d_sat", i), 64'(m_sat), 64'(vt[i].s));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
    end

    // Saturation through the rounding carry, then sat_clr colliding with an increment.
    step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    @(negedge clk);
    chk("sat_clr_idle", 64'(sat_count), 64'd0);
    step();
    cfg_shift = 6'd1;
    issue(42'h8_0000_0001, 35'h7_FFFF_FFFF);
    wait_result(lat);
    chk("carry_sat_data", 64'(m_data), 64'hFFFF_FFFF);
    chk("carry_sat_flag", 64'(m_sat), 64'd1);
    chk("carry_sat_count", 64'(sat_count), 64'd1);
    issue(42'h8_0000_0001, 35'h7_FFFF_FFFF);
    repeat (6) step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_inc_valid", 64'(m_valid), 64'd1);
    chk("clr_vs_inc_count", 64'(sat_count), 64'd0);
    wait_idle();

    // Back-pressure: only DEPTH credits may be taken while downstream stalls.
    step();
    cfg_shift = 6'd20;
    m_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_accepted", 64'(n_acc - a0), 64'd16);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    b0 = n_out;
    step();
    m_ready = 1'b1;
    wait_idle();
    chk("bp_drained", 64'(n_out - b0), 64'd16);

    // Full rate with random operands.
    step();
    cfg_shift = 6'd35;
    first_out = -1;
    a0 = n_acc;
    b0 = n_out;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      rand_ops();
      s_valid = 1'b1;
      @(negedge clk);
      if (!s_ready) drops++;
      step();
    end
    s_valid = 1'b0;
    wait_idle();
    chk("fr_ready_drops", 64'(drops), 64'd0);
    chk("fr_accepted", 64'(n_acc - a0), 64'd100);
    chk("fr_outputs", 64'(n_out - b0), 64'd100);
    chk("fr_consecutive", 64'(last_out - first_out + 1), 64'd100);

    // Reset with 5 products in flight and 3 results in the FIFO.
    step();
    cfg_shift = 6'd3;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_valid", 64'(m_valid), 64'd1);
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd1);
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    step();
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) bad++;
    end
    chk("mid_no_ghosts", 64'(bad), 64'd0);
    chk("mid_idle", 64'(idle), 64'd1);
    m_ready = 1'b1;
    rand_ops();
    p = 70'(77'(dina) * 77'(dinb));
    ref_round(p, cfg_shift, ed, es);
    issue(dina, dinb);
    wait_result(lat);
    chk("mid_after_latency", 64'(lat), 64'd8);
    chk("mid_after_data", 64'(m_data), 64'(ed));
    chk("mid_after_sat", 64'(m_sat), 64'(es));
    wait_idle();

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/math_mult_35_round.md
# math_mult_35_round

Streaming post-processor for the 42x35 DSP48 multiplier (`math_mult_35`). It issues valid/ready flow control for the multiplier's operand side and tracks each accepted operand pair through the fixed 6-cycle multiply pipeline. It captures the 70-bit unsigned product, shifts it right with round-half-up, saturates it to `OUT_W` bits, and buffers results in a FIFO behind an output valid/ready port. Credit-based admission means no product is ever lost to back-pressure, even though the multiplier pipeline never stalls.

## Interface
- `OUT_W`, 32: result width, 1..70.
- `FIFO_DEPTH`, 16: result FIFO entries, power of two, ≥ 2; full throughput requires ≥ `MULT_LAT`+3.
- `MULT_LAT`, 6: multiplier latency in cycles; must equal the instantiated multiplier's latency.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  operand pair presented to the multiplier inputs this cycle.
- `s_ready`  out  1  block can accept an operand pair; the parent gates operand issue with it.
- `prod`  in  70  multiplier `dout`.
- `cfg_shift`  in  6  right-shift amount, 0..63; quasi-static.
- `m_valid`  out  1  result available.
- `m_ready`  in  1  downstream accepts the result.
- `m_data`  out  `OUT_W`  rounded, saturated result.
- `m_sat`  out  1  `m_data` was saturated.
- `sat_clr`  in  1  clears `sat_count`.
- `sat_count`  out  16  saturation event counter.
- `idle`  out  1  nothing in flight and FIFO empty.

## Operation
- Accept: `s_valid && s_ready` at a rising edge. The parent ties multiplier `ena`=1 and `rst`=~`rst_n`.
- Tag line: a 1-bit delay of exactly `MULT_LAT` flops carries the accept strobe. When the tag reaches the end of the line, `prod` is the product of that accepted pair.
- Round stage (1 registered cycle):
  - sum = `prod` + (`cfg_shift`≠0 ? 2^(`cfg_shift`−1) : 0), computed at 71 bits; the carry must not be lost.
  - r = sum >> `cfg_shift`.
  - If any bit of r at or above `OUT_W` is set, data = 2^`OUT_W`−1 and sat=1; otherwise data = r[`OUT_W`−1:0] and sat=0.
- FIFO: the round-stage output is written when its tag is set. `{m_sat, m_data}` come from the FIFO head; the FIFO is registered, with no fall-through.
- Credit counter `cnt` (0..`FIFO_DEPTH`) = items in flight + FIFO occupancy.
  - +1 on accept, −1 on output handshake; both in the same cycle leaves it unchanged.
  - `s_ready` = (`cnt` < `FIFO_DEPTH`), registered-path only; no combinational path from `m_ready`.
  - Consequence: the FIFO can never overflow. An overflow is an assertion failure.
- `sat_count`: +1 per FIFO write with sat=1. It saturates at 0xFFFF. `sat_clr` wins over a simultaneous increment.
- `idle` = (`cnt` == 0).
- `cfg_shift` must be held stable while `idle`=0. A change while busy affects every item not yet through the round stage.
- Reset (asynchronous, any time): tag line, round stage, FIFO pointers, `cnt` and `sat_count` clear. Products still emerging from the multiplier after reset are discarded because their tags are gone.
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `m_sat`=0, `sat_count`=0, `idle`=1.

## Timing
- Accept at cycle t → tag end and `prod` valid at t+`MULT_LAT` → FIFO write at the end of t+`MULT_LAT`+1 → `m_valid` high at t+`MULT_LAT`+2 (t+8 by default).
- Results leave strictly in accept order.
- Throughput: 1 per cycle while `m_ready`=1 and `FIFO_DEPTH` ≥ `MULT_LAT`+3. With a smaller FIFO, `s_ready` periodically drops, but results stay correct.
- `m_valid`/`m_data`/`m_sat` stay stable while `m_valid && !m_ready`.
- When `cnt` reaches `FIFO_DEPTH`, `s_ready` is 0 from the next cycle until a pop edge.

## Structure
- Shared package `math_pkg`:
  - `MATH_MULT_35_LAT` = 6.
  - `MATH_MULT_35_PROD_W` = 70.
  - `MATH_MULT_35_ROUND_SUM_W` = 71.
  - This block's `MULT_LAT` default is taken from the package.
- Sub-module `math_fifo_sync`: a generic registered FIFO with width/depth parameters, full/empty flags, and async active-low reset.
- Tag line, round stage, credit counter and saturation counter live in this module.

## Test plan
- Reset check: hold `rst_n`=0 → `s_ready`=1, `m_valid`=0, `idle`=1, `sat_count`=0; all hold for 10 cycles after release with `s_valid`=0.
- Rounding: `dina`=3, `dinb`=0x8000, `cfg_shift`=16 (product 0x18000) → `m_data`=2, `m_sat`=0, `m_valid` exactly 8 cycles after accept.
- Saturation with carry: `cfg_shift`=1, product 2^70−1 → `m_data`=0xFFFFFFFF, `m_sat`=1, `sat_count`=1. Pulse `sat_clr` in the same cycle as a second saturating write → `sat_count`=0.
- Back-pressure: `m_ready`=0, offer 20 back-to-back pairs → exactly 16 accepted, `s_ready`=0 afterwards. Release `m_ready` → 16 results in order, none lost, then `idle`=1.
- Full rate: `m_ready`=1, 100 back-to-back random pairs, `cfg_shift`=35 → `s_ready` never drops, results on 100 consecutive cycles, all match the reference model.
- Reset mid-stream: assert `rst_n`=0 with 5 items in flight and 3 in the FIFO → after release, no `m_valid` ever appears, `idle`=1, and the next accept produces a correct result after 8 cycles.
